// File: rtl/ovc_credit_status_tracker.sv
// ovc_credit_status_tracker: per-OVC credit counters, ownership and availability for the VC/SW allocator.
// Define OVC_CREDIT_CHECK_EN to add the sticky per-port credit_error_all protocol checker.
module ovc_credit_status_tracker #(
    parameter int    V               = 4,
    parameter int    P               = 5,
    parameter int    B               = 4,
    parameter string VC_REALLOC_TYPE = "NONATOMIC",
    parameter int    MIN_PCK_SIZE    = 2,
    localparam int   PV              = P * V,
    localparam int   CW              = $clog2(B + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PV-1:0]    ovc_allocated_all,
    input  logic [P-1:0]     flit_out_wr_all,
    input  logic [PV-1:0]    flit_out_ovc_num_all,
    input  logic [P-1:0]     flit_out_is_tail_all,
    input  logic [PV-1:0]    credit_in_all,
    output logic [PV-1:0]    ovc_status_all,
    output logic [PV-1:0]    ovc_avail_all,
    output logic [PV-1:0]    ovc_not_full_all,
    output logic [PV-1:0]    ovc_nearly_full_all,
    output logic [PV*CW-1:0] credit_count_all
`ifdef OVC_CREDIT_CHECK_EN
    ,
    output logic [P-1:0]     credit_error_all
`endif
);

    typedef enum logic {FREE = 1'b0, OWNED = 1'b1} ovc_state_t;

    localparam logic [CW-1:0] FULL       = CW'(B);
    localparam bit            ATOMIC     = VC_REALLOC_TYPE == "ATOMIC";
    localparam bit            SC_RELEASE = MIN_PCK_SIZE == 1;

    logic [PV-1:0] underflow;
    logic [PV-1:0] overflow;
    logic [PV-1:0] owned;

    genvar i;
    for (i = 0; i < PV; i++) begin : g_ovc
        ovc_state_t    state_q;
        ovc_state_t    state_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          dec;
        logic          inc;
        logic          rel;

        assign dec          = flit_out_wr_all[i/V] & flit_out_ovc_num_all[i];
        assign inc          = credit_in_all[i];
        assign underflow[i] = dec & ~inc & (cnt_q == '0);
        assign overflow[i]  = inc & ~dec & (cnt_q == FULL);
        assign owned[i]     = state_q == OWNED;
        assign cnt_d        = (dec == inc || underflow[i] || overflow[i]) ? cnt_q :
                              dec ? cnt_q - CW'(1) : cnt_q + CW'(1);
        // A tail frees the OVC even when the grant lands in the same cycle (single-flit packet).
        assign rel          = dec & flit_out_is_tail_all[i/V] &
                              (SC_RELEASE | owned[i] | ovc_allocated_all[i]);
        assign state_d      = rel ? FREE : ovc_allocated_all[i] ? OWNED : state_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q                      <= FREE;
                cnt_q                        <= FULL;
                ovc_status_all[i]            <= 1'b0;
                ovc_avail_all[i]             <= 1'b1;
                ovc_not_full_all[i]          <= 1'b1;
                ovc_nearly_full_all[i]       <= B == 1;
                credit_count_all[i*CW +: CW] <= FULL;
            end else begin
                state_q                      <= state_d;
                cnt_q                        <= cnt_d;
                ovc_status_all[i]            <= state_d == OWNED;
                ovc_avail_all[i]             <= state_d == FREE && (!ATOMIC || cnt_d == FULL);
                ovc_not_full_all[i]          <= cnt_d != '0;
                ovc_nearly_full_all[i]       <= cnt_d == CW'(1);
                credit_count_all[i*CW +: CW] <= cnt_d;
            end
        end
    end

`ifdef OVC_CREDIT_CHECK_EN
    logic [PV-1:0] grant_err;
    logic [P-1:0]  multi_hot;
    logic [P-1:0]  port_err;

    assign grant_err = ovc_allocated_all & owned;

    genvar p;
    for (p = 0; p < P; p++) begin : g_port
        assign multi_hot[p] = flit_out_wr_all[p] & ($countones(flit_out_ovc_num_all[p*V +: V]) > 1);
        assign port_err[p]  = multi_hot[p] |
                              (|(underflow[p*V +: V] | overflow[p*V +: V] | grant_err[p*V +: V]));
    end

    always_ff @(posedge clk) begin
        if (reset)
            credit_error_all <= '0;
        else
            credit_error_all <= credit_error_all | port_err;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < PV; k++) begin
                if (underflow[k])
                    $display("[ovc_credit] underflow port %0d vc %0d", k / V, k % V);
                if (overflow[k])
                    $display("[ovc_credit] overflow port %0d vc %0d", k / V, k % V);
                if (grant_err[k])
                    $display("[ovc_credit] grant to owned ovc port %0d vc %0d", k / V, k % V);
            end
            for (int k = 0; k < P; k++) begin
                if (multi_hot[k])
                    $display("[ovc_credit] multi-hot ovc select port %0d vc mask %b", k,
                             flit_out_ovc_num_all[k*V +: V]);
            end
        end
    end
`endif
`endif

endmodule

// File: tb/tb_ovc_credit_status_tracker.sv
// tb_ovc_credit_status_tracker: directed checks of a NONATOMIC and an ATOMIC instance (V=2, P=2, B=4) fed the same stimulus.
module tb_ovc_credit_status_tracker;

    localparam int V  = 2;
    localparam int P  = 2;
    localparam int B  = 4;
    localparam int PV = P * V;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PV-1:0] alloc = '0;
    logic [P-1:0]  wr = '0;
    logic [PV-1:0] ovc_num = '0;
    logic [P-1:0]  tail = '0;
    logic [PV-1:0] credit = '0;

    logic [PV-1:0]    st_na, av_na, nf_na, nrf_na;
    logic [PV-1:0]    st_at, av_at, nf_at, nrf_at;
    logic [PV*CW-1:0] cc_na, cc_at;
`ifdef OVC_CREDIT_CHECK_EN
    logic [P-1:0]     err_na, err_at;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ovc_credit_status_tracker #(.V(V), .P(P), .B(B), .VC_REALLOC_TYPE("NONATOMIC"), .MIN_PCK_SIZE(1)) dut_na (
        .clk(clk), .reset(reset),
        .ovc_allocated_all(alloc), .flit_out_wr_all(wr), .flit_out_ovc_num_all(ovc_num),
        .flit_out_is_tail_all(tail), .credit_in_all(credit),
        .ovc_status_all(st_na), .ovc_avail_all(av_na), .ovc_not_full_all(nf_na),
        .ovc_nearly_full_all(nrf_na), .credit_count_all(cc_na)
`ifdef OVC_CREDIT_CHECK_EN
        , .credit_error_all(err_na)
`endif
    );

    ovc_credit_status_tracker #(.V(V), .P(P), .B(B), .VC_REALLOC_TYPE("ATOMIC"), .MIN_PCK_SIZE(1)) dut_at (
        .clk(clk), .reset(reset),
        .ovc_allocated_all(alloc), .flit_out_wr_all(wr), .flit_out_ovc_num_all(ovc_num),
        .flit_out_is_tail_all(tail), .credit_in_all(credit),
        .ovc_status_all(st_at), .ovc_avail_all(av_at), .ovc_not_full_all(nf_at),
        .ovc_nearly_full_all(nrf_at), .credit_count_all(cc_at)
`ifdef OVC_CREDIT_CHECK_EN
        , .credit_error_all(err_at)
`endif
    );

    // One clock: inputs set before the call are sampled, outputs are read 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        alloc = '0; wr = '0; ovc_num = '0; tail = '0; credit = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        n_tests++; if (cc_na !== 12'h924) begin n_fail++; $display("FAIL reset_counts got %h want %h", cc_na, 12'h924); end
        n_tests++; if (nf_na !== 4'b1111) begin n_fail++; $display("FAIL reset_not_full got %b want 1111", nf_na); end
        n_tests++; if (av_na !== 4'b1111) begin n_fail++; $display("FAIL reset_avail_na got %b want 1111", av_na); end
        n_tests++; if (av_at !== 4'b1111) begin n_fail++; $display("FAIL reset_avail_at got %b want 1111", av_at); end
        n_tests++; if (st_na !== 4'b0000) begin n_fail++; $display("FAIL reset_status got %b want 0000", st_na); end
        n_tests++; if (nrf_na !== 4'b0000) begin n_fail++; $display("FAIL reset_nearly_full got %b want 0000", nrf_na); end
`ifdef OVC_CREDIT_CHECK_EN
        n_tests++; if (err_na !== 2'b00) begin n_fail++; $display("FAIL reset_error got %b want 00", err_na); end
`endif
    endtask

    task automatic test_drain();
        alloc = 4'b0001;
        cyc();
        n_tests++; if (st_na !== 4'b0001) begin n_fail++; $display("FAIL grant_status got %b want 0001", st_na); end
        n_tests++; if (av_na !== 4'b1110) begin n_fail++; $display("FAIL grant_avail_na got %b want 1110", av_na); end
        n_tests++; if (av_at !== 4'b1110) begin n_fail++; $display("FAIL grant_avail_at got %b want 1110", av_at); end
        for (int k = 1; k <= 4; k++) begin
            wr = 2'b01; ovc_num = 4'b0001;
            cyc();
            n_tests++; if (cc_na[2:0] !== 3'(4 - k)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d want %0d", k, cc_na[2:0], 4 - k); end
            n_tests++; if (nrf_na[0] !== (k == 3)) begin n_fail++; $display("FAIL drain_nearly_full[%0d] got %b want %b", k, nrf_na[0], k == 3); end
            n_tests++; if (nf_na[0] !== (k != 4)) begin n_fail++; $display("FAIL drain_not_full[%0d] got %b want %b", k, nf_na[0], k != 4); end
        end
        n_tests++; if (av_na[0] !== 1'b0) begin n_fail++; $display("FAIL drain_avail got %b want 0", av_na[0]); end
        wr = 2'b01; ovc_num = 4'b0001;
        cyc();
        n_tests++; if (cc_na[2:0] !== 3'd0) begin n_fail++; $display("FAIL underflow_count_na got %0d want 0", cc_na[2:0]); end
        n_tests++; if (cc_at[2:0] !== 3'd0) begin n_fail++; $display("FAIL underflow_count_at got %0d want 0", cc_at[2:0]); end
`ifdef OVC_CREDIT_CHECK_EN
        n_tests++; if (err_na !== 2'b01) begin n_fail++; $display("FAIL underflow_error got %b want 01", err_na); end
`endif
    endtask

    task automatic test_tail_release();
        for (int k = 0; k < 3; k++) begin
            credit = 4'b0001;
            cyc();
        end
        n_tests++; if (cc_na[2:0] !== 3'd3) begin n_fail++; $display("FAIL credit_return_count got %0d want 3", cc_na[2:0]); end
        wr = 2'b01; ovc_num = 4'b0001; tail = 2'b01;
        cyc();
        n_tests++; if (cc_na[2:0] !== 3'd2) begin n_fail++; $display("FAIL tail_count got %0d want 2", cc_na[2:0]); end
        n_tests++; if (st_na[0] !== 1'b0) begin n_fail++; $display("FAIL tail_status_na got %b want 0", st_na[0]); end
        n_tests++; if (st_at[0] !== 1'b0) begin n_fail++; $display("FAIL tail_status_at got %b want 0", st_at[0]); end
        n_tests++; if (av_na[0] !== 1'b1) begin n_fail++; $display("FAIL tail_avail_na got %b want 1", av_na[0]); end
        n_tests++; if (av_at[0] !== 1'b0) begin n_fail++; $display("FAIL tail_avail_at got %b want 0", av_at[0]); end
        credit = 4'b0001;
        cyc();
        n_tests++; if (av_at[0] !== 1'b0) begin n_fail++; $display("FAIL atomic_1st_credit_avail got %b want 0", av_at[0]); end
        n_tests++; if (cc_at[2:0] !== 3'd3) begin n_fail++; $display("FAIL atomic_1st_credit_count got %0d want 3", cc_at[2:0]); end
        credit = 4'b0001;
        cyc();
        n_tests++; if (av_at[0] !== 1'b1) begin n_fail++; $display("FAIL atomic_2nd_credit_avail got %b want 1", av_at[0]); end
        n_tests++; if (cc_at[2:0] !== 3'd4) begin n_fail++; $display("FAIL atomic_2nd_credit_count got %0d want 4", cc_at[2:0]); end
    endtask

    task automatic test_same_cycle();
        wr = 2'b10; ovc_num = 4'b1000;
        cyc();
        n_tests++; if (cc_na[11:9] !== 3'd3) begin n_fail++; $display("FAIL same_cycle_setup got %0d want 3", cc_na[11:9]); end
        wr = 2'b10; ovc_num = 4'b1000; credit = 4'b1000;
        cyc();
        n_tests++; if (cc_na[11:9] !== 3'd3) begin n_fail++; $display("FAIL same_cycle_count got %0d want 3", cc_na[11:9]); end
        n_tests++; if (cc_na[8:6] !== 3'd4) begin n_fail++; $display("FAIL same_cycle_neighbour got %0d want 4", cc_na[8:6]); end
`ifdef OVC_CREDIT_CHECK_EN
        n_tests++; if (err_na[1] !== 1'b0) begin n_fail++; $display("FAIL same_cycle_error got %b want 0", err_na[1]); end
`endif
        credit = 4'b1000;
        cyc();
        n_tests++; if (cc_na[11:9] !== 3'd4) begin n_fail++; $display("FAIL same_cycle_restore got %0d want 4", cc_na[11:9]); end
    endtask

    task automatic test_single_flit();
        alloc = 4'b0100; wr = 2'b10; ovc_num = 4'b0100; tail = 2'b10;
        cyc();
        n_tests++; if (st_na[2] !== 1'b0) begin n_fail++; $display("FAIL single_flit_status_na got %b want 0", st_na[2]); end
        n_tests++; if (st_at[2] !== 1'b0) begin n_fail++; $display("FAIL single_flit_status_at got %b want 0", st_at[2]); end
        n_tests++; if (cc_na[8:6] !== 3'd3) begin n_fail++; $display("FAIL single_flit_count got %0d want 3", cc_na[8:6]); end
        n_tests++; if (av_na[2] !== 1'b1) begin n_fail++; $display("FAIL single_flit_avail_na got %b want 1", av_na[2]); end
        n_tests++; if (av_at[2] !== 1'b0) begin n_fail++; $display("FAIL single_flit_avail_at got %b want 0", av_at[2]); end
        credit = 4'b0100;
        cyc();
        n_tests++; if (av_at[2] !== 1'b1) begin n_fail++; $display("FAIL single_flit_refill_avail_at got %b want 1", av_at[2]); end
    endtask

    task automatic test_overflow();
        credit = 4'b1000;
        cyc();
        n_tests++; if (cc_na[11:9] !== 3'd4) begin n_fail++; $display("FAIL overflow_count got %0d want 4", cc_na[11:9]); end
        n_tests++; if (nrf_na[3] !== 1'b0) begin n_fail++; $display("FAIL overflow_nearly_full got %b want 0", nrf_na[3]); end
        cyc();
`ifdef OVC_CREDIT_CHECK_EN
        n_tests++; if (err_na !== 2'b11) begin n_fail++; $display("FAIL overflow_error_sticky got %b want 11", err_na); end
`endif
        n_tests++; if (cc_at[11:9] !== 3'd4) begin n_fail++; $display("FAIL overflow_hold got %0d want 4", cc_at[11:9]); end
    endtask

    task automatic test_multi_hot();
        wr = 2'b01; ovc_num = 4'b0011;
        cyc();
        n_tests++; if (cc_na[5:0] !== 6'o33) begin n_fail++; $display("FAIL multi_hot_counts got %o want 33", cc_na[5:0]); end
        n_tests++; if (cc_na[11:6] !== 6'o44) begin n_fail++; $display("FAIL multi_hot_other_port got %o want 44", cc_na[11:6]); end
        credit = 4'b0011;
        cyc();
        n_tests++; if (cc_na[5:0] !== 6'o44) begin n_fail++; $display("FAIL multi_hot_restore got %o want 44", cc_na[5:0]); end
    endtask

    task automatic test_back_to_back();
        alloc = 4'b0010;
        cyc();
        alloc = 4'b0010; wr = 2'b01; ovc_num = 4'b0010;
        cyc();
        n_tests++; if (st_na !== 4'b0010) begin n_fail++; $display("FAIL regrant_status got %b want 0010", st_na); end
        n_tests++; if (cc_na[5:3] !== 3'd3) begin n_fail++; $display("FAIL regrant_count got %0d want 3", cc_na[5:3]); end
        wr = 2'b01; ovc_num = 4'b0010; tail = 2'b01; alloc = 4'b0001;
        cyc();
        n_tests++; if (st_na !== 4'b0001) begin n_fail++; $display("FAIL handoff_status got %b want 0001", st_na); end
        n_tests++; if (av_at !== 4'b1100) begin n_fail++; $display("FAIL handoff_avail_at got %b want 1100", av_at); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_tests++; if (cc_na !== 12'h924) begin n_fail++; $display("FAIL mid_reset_counts got %h want %h", cc_na, 12'h924); end
        n_tests++; if (st_at !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_status got %b want 0000", st_at); end
        n_tests++; if (av_at !== 4'b1111) begin n_fail++; $display("FAIL mid_reset_avail got %b want 1111", av_at); end
`ifdef OVC_CREDIT_CHECK_EN
        n_tests++; if (err_na !== 2'b00) begin n_fail++; $display("FAIL mid_reset_error got %b want 00", err_na); end
`endif
    endtask

    initial begin
        test_reset();
        test_drain();
        test_tail_release();
        test_same_cycle();
        test_single_flit();
        test_overflow();
        test_multi_hot();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
